// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA request/priority controller
//   NUM_CH       number of DMA channels
//   ch_t         channel index
//   arb_state_t  request/grant FSM states
//   CMD_*_BIT    command register bit positions of the mode bits
package dma_pkg;
    localparam int NUM_CH = 4;
    localparam int CMD_DISABLE_BIT = 2;
    localparam int CMD_ROTATING_BIT = 4;
    localparam int CMD_DREQ_LOW_BIT = 6;
    localparam int CMD_DACK_HIGH_BIT = 7;
    typedef logic [1:0] ch_t;
    typedef enum logic [1:0] {IDLE, REQ, GRANT, SVC} arb_state_t;
endpackage

// File: rtl/dma_priority_arbiter_if.sv
// dma_priority_arbiter_if: DREQ/HRQ/HLDA/DACK bus and timing-control handshake
//   master: the arbiter (takes dreq/hlda/svc_done/svc_tc, drives hrq/dack/svc_start/active_ch/req_status)
//   slave:  the CPU, request sources and timing control
interface dma_priority_arbiter_if;
    import dma_pkg::*;
    logic [NUM_CH-1:0] dreq;
    logic              hlda;
    logic              hrq;
    logic [NUM_CH-1:0] dack;
    logic              svc_start;
    logic              svc_done;
    logic              svc_tc;
    ch_t               active_ch;
    logic [NUM_CH-1:0] req_status;
    modport master (
        input  dreq, hlda, svc_done, svc_tc,
        output hrq, dack, svc_start, active_ch, req_status
    );
    modport slave (
        output dreq, hlda, svc_done, svc_tc,
        input  hrq, dack, svc_start, active_ch, req_status
    );
endinterface

// File: rtl/dma_prio_encoder.sv
// dma_prio_encoder: rotating-priority encoder, channel i_ptr highest, then i_ptr+1, ... mod NUM_CH
//   i_req     pending requests
//   i_ptr     highest-priority channel (0 gives fixed priority)
//   o_winner  selected channel (i_ptr when nothing pending)
//   o_valid   any request pending
module dma_prio_encoder
    import dma_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  ch_t               i_ptr,
    output ch_t               o_winner,
    output logic              o_valid
);
    ch_t w_idx;
    // Scan from lowest to highest priority so the highest-priority hit is the last one written.
    always_comb begin
        o_winner = i_ptr;
        w_idx = i_ptr;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_idx = i_ptr + ch_t'(i);
            if (i_req[w_idx]) o_winner = w_idx;
        end
        o_valid = |i_req;
    end
endmodule

// File: rtl/dma_priority_arbiter.sv
// dma_priority_arbiter: 8237A-style DREQ qualification, channel priority and HRQ/HLDA/DACK handshake
//   i_clk, i_reset      clock, synchronous active-high reset
//   bus (master)        dreq/hlda in; hrq/dack/svc_start/active_ch/req_status out; svc_done/svc_tc in
//   i_cmd_disable       block new HRQ;   i_cmd_rotating  rotating priority
//   i_cmd_dreq_low      DREQ active low; i_cmd_dack_high DACK active high
//   i_mask_we/wdata     write all mask bits (1 = masked)
//   i_req_we/ch/val     set or clear one software request bit
//   i_autoinit          per-channel autoinitialize: TC does not mask the channel
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    dma_priority_arbiter_if.master bus,
    input  logic                  i_cmd_disable,
    input  logic                  i_cmd_rotating,
    input  logic                  i_cmd_dreq_low,
    input  logic                  i_cmd_dack_high,
    input  logic                  i_mask_we,
    input  logic [NUM_CH-1:0]     i_mask_wdata,
    input  logic                  i_req_we,
    input  ch_t                   i_req_ch,
    input  logic                  i_req_val,
    input  logic [NUM_CH-1:0]     i_autoinit
);
    arb_state_t r_state, w_next;
    logic [NUM_CH-1:0] r_mask, r_sw_req, r_req_status;
    logic [NUM_CH-1:0] w_sreq, w_eff_req, w_onehot, w_grant, w_tc_clr, w_tc_mask, w_mask_next, w_sw_sel, w_sw_next;
    ch_t r_ptr, r_active_ch, w_ptr, w_winner;
    logic w_valid, w_done, w_tc;

    // Polarity is normalised before the synchroniser so every stage holds active-high requests.
    genvar s;
    generate
        for (s = 0; s < SYNC_STAGES; s++) begin : g_sync
            logic [NUM_CH-1:0] r_q;
            if (s == 0) begin : g_first
                always_ff @(posedge i_clk) r_q <= i_reset ? '0 : bus.dreq ^ {NUM_CH{i_cmd_dreq_low}};
            end else begin : g_next
                always_ff @(posedge i_clk) r_q <= i_reset ? '0 : g_sync[s-1].r_q;
            end
        end
    endgenerate
    assign w_sreq = g_sync[SYNC_STAGES-1].r_q;
    assign w_eff_req = (w_sreq & ~r_mask) | r_sw_req;
    assign w_ptr = i_cmd_rotating ? r_ptr : '0;

    dma_prio_encoder u_enc (
        .i_req    (w_eff_req),
        .i_ptr    (w_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (|w_eff_req && !i_cmd_disable) ? REQ : IDLE;
            REQ:     w_next = !bus.hlda ? REQ : (w_valid ? GRANT : IDLE);
            GRANT:   w_next = bus.hlda ? SVC : IDLE;
            SVC:     w_next = (!bus.hlda || bus.svc_done) ? IDLE : SVC;
            default: w_next = IDLE;
        endcase
        w_onehot = NUM_CH'(1) << r_active_ch;
        w_grant = (r_state == GRANT || r_state == SVC) ? w_onehot : '0;
        // An HLDA drop overrides svc_done: aborted services leave mask, sw_req and pointer alone.
        w_done = r_state == SVC && bus.hlda && bus.svc_done;
        w_tc = w_done && bus.svc_tc;
        w_tc_clr = w_tc ? w_onehot : '0;
        w_tc_mask = (w_tc && !i_autoinit[r_active_ch]) ? w_onehot : '0;
        // TC effects are applied after the register writes so they win on their own bit.
        w_mask_next = (i_mask_we ? i_mask_wdata : r_mask) | w_tc_mask;
        w_sw_sel = i_req_we ? (NUM_CH'(1) << i_req_ch) : '0;
        w_sw_next = (i_req_val ? (r_sw_req | w_sw_sel) : (r_sw_req & ~w_sw_sel)) & ~w_tc_clr;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_mask <= '1;
            r_sw_req <= '0;
            r_req_status <= '0;
            r_ptr <= '0;
            r_active_ch <= '0;
        end else begin
            r_state <= w_next;
            r_mask <= w_mask_next;
            r_sw_req <= w_sw_next;
            r_req_status <= w_eff_req;
            if (w_done && i_cmd_rotating) r_ptr <= r_active_ch + ch_t'(1);
            if (r_state == REQ && bus.hlda && w_valid) r_active_ch <= w_winner;
        end
    end

    assign bus.hrq = r_state != IDLE;
    assign bus.svc_start = r_state == GRANT;
    assign bus.dack = ~(w_grant ^ {NUM_CH{i_cmd_dack_high}});
    assign bus.active_ch = r_active_ch;
    assign bus.req_status = r_req_status;
endmodule

// File: tb/tb_dma_priority_arbiter.sv
// tb_dma_priority_arbiter: directed self-checking bench for dma_priority_arbiter
module tb_dma_priority_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_disable, cmd_rotating, cmd_dreq_low, cmd_dack_high;
    logic       mask_we, req_we, req_val;
    logic [3:0] mask_wdata, autoinit;
    logic [1:0] req_ch;
    int         n_cmp = 0;
    int         n_err = 0;

    dma_priority_arbiter_if bus ();

    dma_priority_arbiter dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .bus             (bus),
        .i_cmd_disable   (cmd_disable),
        .i_cmd_rotating  (cmd_rotating),
        .i_cmd_dreq_low  (cmd_dreq_low),
        .i_cmd_dack_high (cmd_dack_high),
        .i_mask_we       (mask_we),
        .i_mask_wdata    (mask_wdata),
        .i_req_we        (req_we),
        .i_req_ch        (req_ch),
        .i_req_val       (req_val),
        .i_autoinit      (autoinit)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_hrq(input string tag);
        for (int i = 0; i < 8 && bus.hrq !== 1'b1; i++) tick(1);
        check({tag, " hrq"}, {7'd0, bus.hrq}, 8'd1);
    endtask

    // Called with the FSM in REQ: grant, start, done, then back to IDLE with HLDA released.
    task automatic serve(input logic [1:0] ch, input logic [3:0] dk, input logic tc, input logic [3:0] nd, input string tag);
        bus.hlda = 1'b1;
        tick(1);
        check({tag, " ch"}, {6'd0, bus.active_ch}, {6'd0, ch});
        check({tag, " dack"}, {4'd0, bus.dack}, {4'd0, dk});
        check({tag, " start"}, {7'd0, bus.svc_start}, 8'd1);
        bus.dreq = nd;
        tick(1);
        check({tag, " start_end"}, {7'd0, bus.svc_start}, 8'd0);
        bus.svc_done = 1'b1;
        bus.svc_tc = tc;
        tick(1);
        bus.svc_done = 1'b0;
        bus.svc_tc = 1'b0;
        bus.hlda = 1'b0;
        check({tag, " hrq_off"}, {7'd0, bus.hrq}, 8'd0);
        check({tag, " dack_off"}, {4'd0, bus.dack}, {4'd0, {4{~cmd_dack_high}}});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cmd_disable = 1'b0; cmd_rotating = 1'b0; cmd_dreq_low = 1'b0; cmd_dack_high = 1'b1;
        mask_we = 1'b0; mask_wdata = 4'h0; req_we = 1'b0; req_ch = 2'd0; req_val = 1'b0; autoinit = 4'h0;
        bus.dreq = 4'h0; bus.hlda = 1'b0; bus.svc_done = 1'b0; bus.svc_tc = 1'b0;
        tick(2);
        check("rst dack_high", {4'd0, bus.dack}, 8'h00);
        cmd_dack_high = 1'b0;
        #1;
        check("rst dack_low", {4'd0, bus.dack}, 8'h0F);
        check("rst hrq", {7'd0, bus.hrq}, 8'd0);
        check("rst start", {7'd0, bus.svc_start}, 8'd0);
        check("rst ch", {6'd0, bus.active_ch}, 8'd0);
        check("rst status", {4'd0, bus.req_status}, 8'h0);
        reset = 1'b0;
        // DREQ edge to HRQ latency, first grant
        mask_we = 1'b1; mask_wdata = 4'h0;
        tick(1);
        mask_we = 1'b0;
        bus.dreq = 4'b0100;
        tick(2);
        check("lat2 hrq", {7'd0, bus.hrq}, 8'd0);
        tick(1);
        check("lat3 hrq", {7'd0, bus.hrq}, 8'd1);
        check("lat3 status", {4'd0, bus.req_status}, 8'h4);
        serve(2'd2, 4'b1011, 1'b0, 4'h0, "first");
        // fixed priority
        bus.dreq = 4'b1010;
        wait_hrq("fix1");
        serve(2'd1, 4'b1101, 1'b0, 4'b1010, "fix1");
        wait_hrq("fix2");
        serve(2'd1, 4'b1101, 1'b0, 4'b1000, "fix2");
        wait_hrq("fix3");
        serve(2'd3, 4'b0111, 1'b0, 4'h0, "fix3");
        // rotating priority
        cmd_rotating = 1'b1;
        bus.dreq = 4'b1111;
        wait_hrq("rot0");
        serve(2'd0, 4'b1110, 1'b0, 4'b1111, "rot0");
        wait_hrq("rot1");
        serve(2'd1, 4'b1101, 1'b0, 4'b1111, "rot1");
        wait_hrq("rot2");
        serve(2'd2, 4'b1011, 1'b0, 4'b1111, "rot2");
        wait_hrq("rot3");
        serve(2'd3, 4'b0111, 1'b0, 4'b1111, "rot3");
        wait_hrq("rot4");
        serve(2'd0, 4'b1110, 1'b0, 4'h0, "rot4");
        cmd_rotating = 1'b0;
        // terminal count masks the channel unless autoinit
        bus.dreq = 4'b0001;
        wait_hrq("tc");
        serve(2'd0, 4'b1110, 1'b1, 4'h0, "tc");
        bus.dreq = 4'b0001;
        tick(4);
        check("tc masked hrq", {7'd0, bus.hrq}, 8'd0);
        check("tc masked status", {4'd0, bus.req_status}, 8'h0);
        mask_we = 1'b1; mask_wdata = 4'h0;
        tick(1);
        mask_we = 1'b0;
        wait_hrq("ai");
        autoinit = 4'b0001;
        serve(2'd0, 4'b1110, 1'b1, 4'h0, "ai");
        bus.dreq = 4'b0001;
        wait_hrq("ai unmasked");
        serve(2'd0, 4'b1110, 1'b0, 4'h0, "ai2");
        autoinit = 4'h0;
        // request withdrawn before HLDA
        bus.dreq = 4'b0100;
        wait_hrq("wd");
        bus.dreq = 4'h0;
        tick(2);
        bus.hlda = 1'b1;
        tick(1);
        check("wd hrq", {7'd0, bus.hrq}, 8'd0);
        check("wd dack", {4'd0, bus.dack}, 8'h0F);
        check("wd start", {7'd0, bus.svc_start}, 8'd0);
        bus.hlda = 1'b0;
        tick(1);
        check("wd idle", {7'd0, bus.hrq}, 8'd0);
        // HLDA dropped during service
        bus.dreq = 4'b0010;
        wait_hrq("ab");
        bus.hlda = 1'b1;
        tick(1);
        check("ab grant dack", {4'd0, bus.dack}, 8'hD);
        tick(1);
        check("ab svc dack", {4'd0, bus.dack}, 8'hD);
        bus.hlda = 1'b0;
        tick(1);
        check("ab dack", {4'd0, bus.dack}, 8'hF);
        check("ab hrq", {7'd0, bus.hrq}, 8'd0);
        tick(1);
        check("ab rereq", {7'd0, bus.hrq}, 8'd1);
        check("ab status", {4'd0, bus.req_status}, 8'h2);
        serve(2'd1, 4'b1101, 1'b0, 4'h0, "ab");
        // software request ignores mask; TC clear and TC mask win simultaneous writes
        mask_we = 1'b1; mask_wdata = 4'hF;
        bus.dreq = 4'b1000;
        tick(1);
        mask_we = 1'b0;
        req_we = 1'b1; req_ch = 2'd3; req_val = 1'b1;
        tick(1);
        req_we = 1'b0;
        wait_hrq("sw");
        check("sw status", {4'd0, bus.req_status}, 8'h8);
        bus.hlda = 1'b1;
        tick(1);
        check("sw ch", {6'd0, bus.active_ch}, 8'd3);
        tick(1);
        bus.svc_done = 1'b1; bus.svc_tc = 1'b1;
        mask_we = 1'b1; mask_wdata = 4'h0;
        req_we = 1'b1; req_ch = 2'd3; req_val = 1'b1;
        tick(1);
        bus.svc_done = 1'b0; bus.svc_tc = 1'b0; bus.hlda = 1'b0;
        mask_we = 1'b0; req_we = 1'b0;
        tick(4);
        check("sw tc hrq", {7'd0, bus.hrq}, 8'd0);
        check("sw tc status", {4'd0, bus.req_status}, 8'h0);
        // cmd_disable blocks new HRQ
        mask_we = 1'b1; mask_wdata = 4'h0;
        cmd_disable = 1'b1;
        bus.dreq = 4'b0001;
        tick(1);
        mask_we = 1'b0;
        tick(5);
        check("dis hrq", {7'd0, bus.hrq}, 8'd0);
        check("dis status", {4'd0, bus.req_status}, 8'h1);
        cmd_disable = 1'b0;
        tick(1);
        check("dis release hrq", {7'd0, bus.hrq}, 8'd1);
        cmd_dack_high = 1'b1;
        serve(2'd0, 4'b0001, 1'b0, 4'h0, "dackhi");
        // active-low DREQ
        cmd_dreq_low = 1'b1;
        bus.dreq = 4'b1111;
        tick(4);
        check("dlow idle", {7'd0, bus.hrq}, 8'd0);
        bus.dreq = 4'b1101;
        wait_hrq("dlow");
        serve(2'd1, 4'b0010, 1'b0, 4'b1111, "dlow");
        tick(3);
        check("dlow done", {7'd0, bus.hrq}, 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Request/priority controller for the 4-channel 8237A-style DMA core.
- Synchronises and qualifies DREQ lines, merges them with software requests and the mask register, and picks one channel by fixed or rotating priority.
- Runs the HRQ/HLDA bus handshake with the CPU, drives DACK, and hands the granted channel to the timing-control block through a start/done handshake.

Parameters:
NUM_CH, 4, number of DMA channels (design and tests fixed at 4)
SYNC_STAGES, 2, flops in the DREQ synchroniser

Ports:
CLK  input  1  system clock; all logic on posedge
RESET  input  1  synchronous, active-high reset
DREQ  input  4  asynchronous channel request lines; polarity set by cmd_dreq_low
HLDA  input  1  hold acknowledge from the CPU
cmd_disable  input  1  command bit 2; 1 = no new HRQ
cmd_rotating  input  1  command bit 4; 1 = rotating priority, 0 = fixed
cmd_dreq_low  input  1  command bit 6; 1 = DREQ active low
cmd_dack_high  input  1  command bit 7; 1 = DACK active high
mask_we  input  1  write all four mask bits
mask_wdata  input  4  mask value; 1 = masked
req_we  input  1  software request write
req_ch  input  2  software request channel
req_val  input  1  set (1) or clear (0) the software request bit
autoinit  input  4  per-channel autoinitialize mode bit
svc_done  input  1  one-cycle pulse from timing control: service ended
svc_tc  input  1  qualifies svc_done: terminal count or EOP reached
HRQ  output  1  hold request to the CPU
DACK  output  4  channel acknowledge; polarity set by cmd_dack_high
svc_start  output  1  one-cycle pulse to timing control: begin service
active_ch  output  2  granted channel, valid while DACK is active
req_status  output  4  pending effective requests, for the status register

Behaviour:
- Reset (RESET=1 on a clock edge):
  - State IDLE; HRQ=0; svc_start=0; active_ch=0.
  - DACK at its inactive level: all bits = ~cmd_dack_high.
  - mask=4'b1111; software request register = 0; priority pointer = 0 (ch0 highest); synchroniser flops = 0.
  - Reset mid-service aborts immediately with the same values.
- Request qualification:
  - sreq = synchronised (DREQ ^ {4{cmd_dreq_low}}).
  - eff_req = (sreq & ~mask) | sw_req. The software request ignores the mask.
  - req_status = eff_req, registered.
- Priority:
  - Fixed mode: ch0 > ch1 > ch2 > ch3.
  - Rotating mode: the highest-priority channel is ptr, then ptr+1, and so on, mod 4.
  - After svc_done on channel n in rotating mode, ptr = (n+1) mod 4. In fixed mode ptr stays 0.
- FSM states: IDLE, REQ, GRANT, SVC.
  - IDLE: if eff_req != 0 and cmd_disable=0, go to REQ and set HRQ=1. Latency from a DREQ edge to HRQ is SYNC_STAGES+1 cycles (3 by default).
  - REQ: HRQ held at 1. Wait for HLDA=1, sampled on a clock edge.
    - On HLDA with eff_req != 0, arbitrate now (not at request time). Latch the winner into active_ch and go to GRANT.
    - On HLDA with eff_req == 0 (request withdrawn), set HRQ=0 and return to IDLE with no DACK.
  - GRANT: one cycle. DACK[active_ch] goes active and svc_start=1. Go to SVC.
  - SVC: DACK held. On svc_done, go to IDLE the next cycle; HRQ and DACK go inactive together.
    - If svc_tc=1: clear sw_req[active_ch], and set mask[active_ch] unless autoinit[active_ch]=1.
  - HLDA dropping to 0 in GRANT or SVC: abort to IDLE next cycle, HRQ=0, DACK inactive, no mask or pointer update.
- After returning to IDLE, HRQ stays 0 for at least 1 cycle before a new request.
- cmd_disable=1 blocks only the IDLE→REQ transition. A service already in progress runs to completion.
- Simultaneous events:
  - The TC mask set has priority over mask_we in the same cycle, for that bit only.
  - req_we and a TC clear of the same bit in the same cycle: the TC clear wins.
- DACK polarity tracks cmd_dack_high combinationally. DACK[i] = (grant_i) XNOR cmd_dack_high.

Decomposition:
- Shared package dma_pkg:
  - typedef enum arb_state_t {IDLE, REQ, GRANT, SVC}.
  - NUM_CH.
  - Channel-index typedef ch_t (2 bits).
  - Command-bit position constants.
- One sub-module, dma_prio_encoder: combinational rotating-priority encoder (eff_req, ptr → winner, valid).
- The synchroniser stays inline as a generate loop.

Test Plan:
- Reset, mask=0, DREQ=4'b0100 (active high) → HRQ=1 3 cycles later. HLDA=1 → next cycle DACK=4'b1011 (active low), svc_start pulses, active_ch=2.
- Fixed mode, DREQ=4'b1010 → ch1 granted. After svc_done, ch3 granted. Repeat with ch1 still requesting → ch1 wins again.
- Rotating mode, DREQ=4'b1111 → grant order 0,1,2,3,0, one channel per HRQ/HLDA cycle.
- Grant ch0 with svc_done+svc_tc: autoinit[0]=0 → mask becomes 4'b0001; autoinit[0]=1 → mask stays 4'b0000.
- DREQ released while in REQ, then HLDA=1 → HRQ falls and DACK never asserts. Separately, HLDA dropped in SVC → DACK inactive next cycle, mask unchanged.
- mask=4'b1111, req_we ch3 → ch3 granted with DREQ all 0. cmd_disable=1 with pending DREQ → HRQ stays 0.
